bit_unstuffer: RTL and testbench
================================

Name: bit_unstuffer

Overview:
Receive-path stage directly downstream of the NRZI decoder. It consumes the decoded serial bit stream (out_bit / nrzi_sending) and removes the stuffed 0 that USB inserts after every six consecutive 1s. It flags a bit-stuffing violation and forwards a bit stream with a per-bit valid qualifier to the downstream PID/packet assembler.

Parameters:
MAX_ONES, 6, number of consecutive 1s after which the next bit is a stuffed bit
CNT_W, 3, width of the ones counter; must satisfy 2^CNT_W > MAX_ONES

Ports:
clock  input  1  single system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
in_bit  input  1  decoded bit from NRZI decoder, meaningful only while nrzi_sending=1
nrzi_sending  input  1  high for every cycle carrying a packet bit from the NRZI decoder
out_bit  output  1  unstuffed data bit, meaningful only when bit_valid=1
bit_valid  output  1  high for one cycle per forwarded (non-stuffed) bit
unstuff_sending  output  1  high while a packet is being forwarded; 1-cycle-delayed copy of packet activity
stuff_error  output  1  one-cycle pulse when a 1 arrives where a stuffed 0 was required

Behaviour:
- Reset is asynchronous and active-high. On assertion, at any time including mid-packet: state=IDLE, ones_cnt=0, out_bit=0, bit_valid=0, unstuff_sending=0, stuff_error=0.
- All outputs are registered. Latency is 1 cycle from input sample to output.
- FSM states: IDLE, RECV, ERR.
- IDLE:
  - nrzi_sending=0: remain in IDLE; all outputs 0 next cycle.
  - nrzi_sending=1: process this cycle's in_bit exactly as in RECV with ones_cnt=0, then go to RECV.
- RECV, each cycle with nrzi_sending=1:
  - ones_cnt < MAX_ONES: forward the bit. Next cycle out_bit=in_bit, bit_valid=1, unstuff_sending=1. ones_cnt becomes ones_cnt+1 if in_bit=1, else 0.
  - ones_cnt == MAX_ONES and in_bit=0: stuffed bit, dropped. Next cycle bit_valid=0, unstuff_sending=1, out_bit holds its previous value. ones_cnt=0.
  - ones_cnt == MAX_ONES and in_bit=1: violation. Next cycle stuff_error=1 for exactly one cycle, bit_valid=0, unstuff_sending=0. ones_cnt=0. Go to ERR.
- RECV with nrzi_sending=0 (end of packet): go to IDLE, ones_cnt=0. Next cycle bit_valid=0 and unstuff_sending=0. No error is raised even if ones_cnt==MAX_ONES at that point.
- ERR: bit_valid=0, unstuff_sending=0, stuff_error=0. Stay in ERR while nrzi_sending=1; all remaining packet bits are discarded. When nrzi_sending=0, go to IDLE.
- ones_cnt saturates conceptually at MAX_ONES; it never exceeds MAX_ONES and never wraps.
- A stuffed 0 resets the run, so 1,1,1,1,1,1,0,1,1,1,1,1,1,0 unstuffs to twelve 1s.
- Back-to-back packets: if nrzi_sending drops for a single cycle and reasserts, the new packet starts from IDLE with ones_cnt=0.
- The first packet bit (forced to 1 by the NRZI decoder) is treated as ordinary data and counts toward ones_cnt.
- bit_valid and stuff_error are never high in the same cycle.

Test Plan:
- Reset mid-packet: assert reset while bit_valid=1 and ones_cnt=4 -> all outputs 0 immediately (asynchronous); after release with nrzi_sending=0, the block stays in IDLE.
- Plain byte: nrzi_sending=1 for 8 cycles with bits 0,0,0,0,0,0,0,1 -> eight bit_valid pulses, out_bit sequence identical, starting 1 cycle after the first input; unstuff_sending falls 1 cycle after nrzi_sending.
- Single stuff: bits 1,1,1,1,1,1,0,1 -> 7 valid bits, all 1; bit_valid=0 exactly in the cycle corresponding to the 7th input; no stuff_error.
- Violation: bits 1,1,1,1,1,1,1 then 0,1,0 with nrzi_sending held high -> stuff_error pulse one cycle after the 7th bit; no further bit_valid until nrzi_sending falls; the next packet is processed normally.
- Packet ends after six 1s: bits 1×6, then nrzi_sending=0 -> six valid bits, no stuff_error, IDLE reached.
- Double stuff: 1×6,0,1×6,0,0 -> thirteen valid bits (twelve 1s then a 0); two dropped cycles.

Source files
------------

// File: rtl/bit_unstuffer_if.sv
// Bus between the NRZI decoder, the bit unstuffer and the packet assembler.
// Debug taps expose the unstuffer's FSM state and ones run counter.
interface bit_unstuffer_if #(
  parameter int CNT_W = 3
);
  // Handshake: no backpressure. nrzi_sending qualifies in_bit every cycle it is
  // high; bit_valid qualifies out_bit for exactly the cycle it is high, and the
  // consumer must accept it then. unstuff_sending frames the forwarded packet.
  logic             in_bit;
  logic             nrzi_sending;
  logic             out_bit;
  logic             bit_valid;
  logic             unstuff_sending;
  logic             stuff_error;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_ones_cnt;

  modport master (
    output in_bit,
    output nrzi_sending,
    input  out_bit,
    input  bit_valid,
    input  unstuff_sending,
    input  stuff_error,
    input  dbg_state,
    input  dbg_ones_cnt
  );

  modport slave (
    input  in_bit,
    input  nrzi_sending,
    output out_bit,
    output bit_valid,
    output unstuff_sending,
    output stuff_error,
    output dbg_state,
    output dbg_ones_cnt
  );
endinterface

// File: rtl/bit_unstuffer.sv
// USB receive bit unstuffer: drops the 0 stuffed after MAX_ONES consecutive 1s,
// flags a 1 in that slot as a stuffing violation. All outputs registered.
module bit_unstuffer #(
  parameter int MAX_ONES = 6,
  parameter int CNT_W    = 3
) (
  input  logic         clock,
  input  logic         reset,
  bit_unstuffer_if.slave bus
);

  if ((2 ** CNT_W) <= MAX_ONES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_ONES");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ONES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic             out_bit_q, out_bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             sending_q, sending_d;
  logic             stuff_error_q, stuff_error_d;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ones_cnt_q    <= '0;
      out_bit_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      sending_q     <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_cnt_q    <= ones_cnt_d;
      out_bit_q     <= out_bit_d;
      bit_valid_q   <= bit_valid_d;
      sending_q     <= sending_d;
      stuff_error_q <= stuff_error_d;
    end
  end

  // A packet starting from IDLE always begins with an empty run of ones.
  assign run_cnt = (state_q == IDLE) ? '0 : ones_cnt_q;

  always_comb begin
    state_d       = state_q;
    ones_cnt_d    = ones_cnt_q;
    out_bit_d     = out_bit_q;
    bit_valid_d   = 1'b0;
    sending_d     = 1'b0;
    stuff_error_d = 1'b0;

    unique case (state_q)
      IDLE, RECV: begin
        if (bus.nrzi_sending) begin
          state_d = RECV;
          if (run_cnt < MAX_CNT) begin
            out_bit_d   = bus.in_bit;
            bit_valid_d = 1'b1;
            sending_d   = 1'b1;
            ones_cnt_d  = bus.in_bit ? (run_cnt + ONE_CNT) : '0;
          end else if (!bus.in_bit) begin
            // Stuffed 0: swallowed, but the packet frame stays open.
            sending_d  = 1'b1;
            ones_cnt_d = '0;
          end else begin
            stuff_error_d = 1'b1;
            ones_cnt_d    = '0;
            state_d       = ERR;
          end
        end else begin
          state_d    = IDLE;
          ones_cnt_d = '0;
          if (state_q == IDLE) begin
            out_bit_d = 1'b0;
          end
        end
      end
      ERR: begin
        ones_cnt_d = '0;
        if (!bus.nrzi_sending) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        ones_cnt_d = '0;
      end
    endcase
  end

  assign bus.out_bit         = out_bit_q;
  assign bus.bit_valid       = bit_valid_q;
  assign bus.unstuff_sending = sending_q;
  assign bus.stuff_error     = stuff_error_q;
  assign bus.dbg_state       = state_q;
  assign bus.dbg_ones_cnt    = ones_cnt_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// Bench for bit_unstuffer: directed USB stuffing cases plus random packets,
// checked cycle by cycle against a packet-level reference model.
module tb_bit_unstuffer;

  localparam int MAX_ONES = 6;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  bit_unstuffer_if #(.CNT_W(3)) bus ();

  bit_unstuffer #(.MAX_ONES(MAX_ONES), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Tracks whether the previous cycle was inside a packet, the current run of
  // 1s in that packet, whether the packet was aborted, and the last data bit.
  logic [3:0] exp_q[$];   // {stuff_error, unstuff_sending, bit_valid, out_bit}
  bit m_in_pkt;
  bit m_aborted;
  int m_run;
  bit m_last_out;

  task automatic model_reset();
    m_in_pkt   = 0;
    m_aborted  = 0;
    m_run      = 0;
    m_last_out = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit sending, input bit b);
    bit v, s, e;
    v = 0; s = 0; e = 0;
    if (!sending) begin
      if (!m_in_pkt) m_last_out = 0;
      m_in_pkt  = 0;
      m_run     = 0;
      m_aborted = 0;
    end else begin
      if (!m_in_pkt) begin
        m_run     = 0;
        m_aborted = 0;
      end
      m_in_pkt = 1;
      if (!m_aborted) begin
        if (m_run == MAX_ONES) begin
          m_run = 0;
          if (b) begin
            e = 1;
            m_aborted = 1;
          end else begin
            s = 1;
          end
        end else begin
          v = 1;
          s = 1;
          m_last_out = b;
          m_run = b ? m_run + 1 : 0;
        end
      end
    end
    exp_q.push_back({e, s, v, m_last_out});
  endtask

  // ---------------- checks ----------------
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    logic [3:0] e;
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stuff_error",     bus.stuff_error,     e[3]);
      chk("unstuff_sending", bus.unstuff_sending, e[2]);
      chk("bit_valid",       bus.bit_valid,       e[1]);
      chk("out_bit",         bus.out_bit,         e[0]);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are checked 1 time
  // unit after the following edge.
  task automatic drive(input bit sending, input bit b);
    bus.nrzi_sending = sending;
    bus.in_bit       = b;
    model_step(sending, b);
    @(posedge clock);
    #1;
    chk_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_packet(input logic [63:0] bits, input int len);
    for (int i = 0; i < len; i++) drive(1'b1, bits[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] pk;
    int len;
    total = 0;
    bad   = 0;
    bus.nrzi_sending = 1'b0;
    bus.in_bit       = 1'b0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("reset_valid",   bus.bit_valid, 1'b0);
    chk("reset_sending", bus.unstuff_sending, 1'b0);
    chk("reset_err",     bus.stuff_error, 1'b0);
    chk("reset_out",     bus.out_bit, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // Reset mid-packet after four 1s: asynchronous clear.
    send_packet(64'hF, 4);
    chk("pre_reset_valid", bus.bit_valid, 1'b1);
    total++;
    assert (bus.dbg_ones_cnt === 3'd4) else begin
      bad++;
      $error("FAIL pre_reset_cnt observed=%0d expected=4", bus.dbg_ones_cnt);
    end
    #2;
    bus.nrzi_sending = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_valid",   bus.bit_valid, 1'b0);
    chk("async_sending", bus.unstuff_sending, 1'b0);
    chk("async_err",     bus.stuff_error, 1'b0);
    chk("async_out",     bus.out_bit, 1'b0);
    total++;
    assert (bus.dbg_ones_cnt === 3'd0) else begin
      bad++;
      $error("FAIL async_cnt observed=%0d expected=0", bus.dbg_ones_cnt);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    idle(3);

    // Plain byte 0,0,0,0,0,0,0,1 (LSB first in the vector).
    send_packet(64'h80, 8);
    idle(2);
    // Single stuff: 1x6,0,1.
    send_packet(64'hBF, 8);
    idle(2);
    // Violation: 1x7 then 0,1,0 with sending held, then a normal packet.
    send_packet(64'h27F, 10);
    idle(1);
    send_packet(64'hA5, 8);
    idle(2);
    // Packet ends right after six 1s.
    send_packet(64'h3F, 6);
    idle(2);
    // Double stuff: 1x6,0,1x6,0,0.
    send_packet(64'h1FBF, 15);
    idle(1);
    // Back-to-back after a single idle cycle starting with five 1s.
    send_packet(64'h1F, 5);
    idle(1);
    send_packet(64'h3, 2);
    idle(2);

    // Random packets biased toward 1s so stuffing and violations occur.
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < 64; i++) pk[i] = ($urandom_range(0, 9) < 8);
      send_packet(pk, len);
      idle($urandom_range(1, 3));
    end

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
